// File: rtl/alu_op_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_pkg
// Description : Shared RV32I opcode and ALU operation encodings. The ALU
//               imports this same package so both ends of the ID/EX
//               boundary agree on the 4-bit Operation code.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_op_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct3 values for the arithmetic (R/I) group
    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_sr      = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;

    // funct3 values for the branch group
    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;
    localparam logic [2:0] c_f3_blt = 3'b100;
    localparam logic [2:0] c_f3_bge = 3'b101;

    // ALU operation codes
    localparam int ALU_OP_WIDTH = 4;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_JAL = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_BEQ = 4'b1000;
    localparam logic [3:0] ALU_BNE = 4'b1001;
    localparam logic [3:0] ALU_BGE = 4'b1010;
    localparam logic [3:0] ALU_LUI = 4'b1011;
    localparam logic [3:0] ALU_SLT = 4'b1100;
    localparam logic [3:0] ALU_SRA = 4'b1110;
    localparam logic [3:0] ALU_SRL = 4'b1111;

    // Decoder result: operation code plus unsupported-instruction flag
    typedef struct packed {
        logic [3:0] operation;
        logic       illegal;
    } alu_dec_t;

    // Supported instruction with the given operation code
    function automatic alu_dec_t alu_legal(input logic [3:0] op);
        alu_dec_t r;
        r.operation = op;
        r.illegal   = 1'b0;
        return r;
    endfunction

    // Unsupported instruction: code is forced to 0000 so the ALU sees a benign AND
    function automatic alu_dec_t alu_illegal();
        alu_dec_t r;
        r.operation = ALU_AND;
        r.illegal   = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Purely combinational map from RV32I opcode/funct3/funct7 to
//               the ALU Operation code, with an illegal flag for anything
//               the ALU cannot execute.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_op_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [6:0]               i_opcode,
    input  logic [2:0]               i_funct3,
    input  logic [6:0]               i_funct7,
    output logic [OPCODE_LENGTH-1:0] o_operation,
    output logic                     o_illegal
);

    alu_dec_t w_arith;
    alu_dec_t w_branch;
    alu_dec_t w_dec;

    // Only funct7[5] selects between operation variants; the other bits
    // are don't-care for every supported instruction.
    logic w_unused_funct7;
    assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

    // Arithmetic group shared by R-type and I-type; funct3=000 defaults to ADD
    // and the R-type SUB override is applied in the opcode mux below.
    always_comb begin
        w_arith = alu_illegal();
        case (i_funct3)
            c_f3_add_sub: w_arith = alu_legal(ALU_ADD);
            c_f3_sll:     w_arith = alu_legal(ALU_SLL);
            c_f3_slt:     w_arith = alu_legal(ALU_SLT);
            c_f3_sltu:    w_arith = alu_illegal();
            c_f3_xor:     w_arith = alu_legal(ALU_XOR);
            c_f3_sr:      w_arith = alu_legal(i_funct7[5] ? ALU_SRA : ALU_SRL);
            c_f3_or:      w_arith = alu_legal(ALU_OR);
            c_f3_and:     w_arith = alu_legal(ALU_AND);
            default:      w_arith = alu_illegal();
        endcase
    end

    // Branch group; unsigned compares have no ALU support and trap
    always_comb begin
        w_branch = alu_illegal();
        case (i_funct3)
            c_f3_beq: w_branch = alu_legal(ALU_BEQ);
            c_f3_bne: w_branch = alu_legal(ALU_BNE);
            c_f3_blt: w_branch = alu_legal(ALU_SLT);
            c_f3_bge: w_branch = alu_legal(ALU_BGE);
            default:  w_branch = alu_illegal();
        endcase
    end

    // Top-level opcode select
    always_comb begin
        w_dec = alu_illegal();
        case (i_opcode)
            OP_R: begin
                if ((i_funct3 == c_f3_add_sub) && i_funct7[5]) begin
                    w_dec = alu_legal(ALU_SUB);
                end else begin
                    w_dec = w_arith;
                end
            end
            OP_I:              w_dec = w_arith;
            OP_LOAD, OP_STORE: w_dec = alu_legal(ALU_ADD);
            OP_BRANCH:         w_dec = w_branch;
            OP_LUI:            w_dec = alu_legal(ALU_LUI);
            OP_JAL, OP_JALR:   w_dec = alu_legal(ALU_JAL);
            default:           w_dec = alu_illegal();
        endcase
    end

    assign o_operation = OPCODE_LENGTH'(w_dec.operation);
    assign o_illegal   = w_dec.illegal;

endmodule
`default_nettype wire

// File: rtl/alu_op_encoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_encoder
// Description : ID->EX producer of the ALU Operation code. Decodes incoming
//               instruction fields and holds the results in a 2-entry skid
//               buffer with registered ready, synchronous flush and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_encoder
    import alu_op_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_operation,
    output logic                     out_illegal,
    output logic [TAG_WIDTH-1:0]     out_tag
);

    // Datapath width is carried only to keep the parameter set aligned with the ALU
    localparam int c_unused_data_width = DATA_WIDTH;

    // Occupancy encoding
    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    // Decoded view of the incoming instruction
    logic [OPCODE_LENGTH-1:0] w_dec_operation;
    logic                     w_dec_illegal;

    // Buffer state: head is what EX sees, tail is the skid slot
    logic [1:0]               r_count;
    logic [1:0]               w_count_next;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [OPCODE_LENGTH-1:0] r_head_operation;
    logic                     r_head_illegal;
    logic [TAG_WIDTH-1:0]     r_head_tag;
    logic [OPCODE_LENGTH-1:0] r_tail_operation;
    logic                     r_tail_illegal;
    logic [TAG_WIDTH-1:0]     r_tail_tag;

    logic                     w_enq;
    logic                     w_deq;

    alu_op_decode #(
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_decode (
        .i_opcode    (in_opcode),
        .i_funct3    (in_funct3),
        .i_funct7    (in_funct7),
        .o_operation (w_dec_operation),
        .o_illegal   (w_dec_illegal)
    );

    // Flush wins over a same-cycle enqueue; a same-cycle dequeue still
    // happens from EX's point of view, it just has no effect on state.
    assign w_enq = in_valid && r_in_ready && !flush;
    assign w_deq = r_out_valid && out_ready;

    // Next occupancy; enqueue at full cannot happen because ready is low
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = c_empty;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   w_count_next = r_count + 2'd1;
                2'b01:   w_count_next = r_count - 2'd1;
                default: w_count_next = r_count;
            endcase
        end
    end

    // Occupancy plus registered handshake flags derived from next occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= c_empty;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_in_ready  <= (w_count_next < c_full);
            r_out_valid <= (w_count_next != c_empty);
        end
    end

    // Entry storage: FIFO order, new entry goes to head when the head is
    // empty or leaving this cycle, otherwise to the skid slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_operation <= '0;
            r_head_illegal   <= 1'b0;
            r_head_tag       <= '0;
            r_tail_operation <= '0;
            r_tail_illegal   <= 1'b0;
            r_tail_tag       <= '0;
        end else begin
            case (r_count)
                c_empty: begin
                    if (w_enq) begin
                        r_head_operation <= w_dec_operation;
                        r_head_illegal   <= w_dec_illegal;
                        r_head_tag       <= in_tag;
                    end
                end
                c_one: begin
                    if (w_enq && w_deq) begin
                        r_head_operation <= w_dec_operation;
                        r_head_illegal   <= w_dec_illegal;
                        r_head_tag       <= in_tag;
                    end else if (w_enq) begin
                        r_tail_operation <= w_dec_operation;
                        r_tail_illegal   <= w_dec_illegal;
                        r_tail_tag       <= in_tag;
                    end
                end
                c_full: begin
                    if (w_deq) begin
                        r_head_operation <= r_tail_operation;
                        r_head_illegal   <= r_tail_illegal;
                        r_head_tag       <= r_tail_tag;
                    end
                end
                default: begin
                    r_head_operation <= r_head_operation;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_operation = r_head_operation;
    assign out_illegal   = r_head_illegal;
    assign out_tag       = r_head_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_encoder
// Description : Self-checking bench for alu_op_encoder. Expected entries are
//               queued when the DUT accepts an input and compared when EX
//               consumes the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_operation;
    logic        out_illegal;
    logic [31:0] out_tag;

    typedef struct packed {
        logic [3:0]  op;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] opcs [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b1101111, 7'b1100111,
                             7'b1110011};

    alu_op_encoder #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (4),
        .TAG_WIDTH     (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_funct7     (in_funct7),
        .in_tag        (in_tag),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operation (out_operation),
        .out_illegal   (out_illegal),
        .out_tag       (out_tag)
    );

    always #5 clk = ~clk;

    // Reference decode table: returns {illegal, operation}
    function automatic logic [4:0] ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic [6:0] f7);
        logic [4:0] r;
        r = 5'b10000;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            case (f3)
                3'd0: r = (opc == 7'b0110011 && f7[5]) ? 5'b00110 : 5'b00010;
                3'd1: r = 5'b00111;
                3'd2: r = 5'b01100;
                3'd3: r = 5'b10000;
                3'd4: r = 5'b00101;
                3'd5: r = f7[5] ? 5'b01110 : 5'b01111;
                3'd6: r = 5'b00001;
                default: r = 5'b00000;
            endcase
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            r = 5'b00010;
        end else if (opc == 7'b1100011) begin
            case (f3)
                3'd0: r = 5'b01000;
                3'd1: r = 5'b01001;
                3'd4: r = 5'b01100;
                3'd5: r = 5'b01010;
                default: r = 5'b10000;
            endcase
        end else if (opc == 7'b0110111) begin
            r = 5'b01011;
        end else if (opc == 7'b1101111 || opc == 7'b1100111) begin
            r = 5'b00011;
        end
        return r;
    endfunction

    task automatic drive_in(input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] tag);
        in_valid  = 1'b1;
        in_opcode = opc;
        in_funct3 = f3;
        in_funct7 = f7;
        in_tag    = tag;
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        in_opcode = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_tag    = '0;
    endtask

    // Model push: called at the negedge before the edge that would accept
    task automatic sb_accept();
        logic [4:0] r;
        exp_t       e;
        if (in_valid && in_ready && !flush) begin
            r     = ref_decode(in_opcode, in_funct3, in_funct7);
            e.op  = r[3:0];
            e.ill = r[4];
            e.tag = in_tag;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_operation, out_illegal, out_tag} !== {1'b1, 1'b0, 4'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b vld=%b op=%b ill=%b tag=%h, want rdy=1 vld=0 op=0000 ill=0 tag=0",
                     in_ready, out_valid, out_operation, out_illegal, out_tag);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
        out_ready = 1'b1;
        drive_in(7'b0110011, 3'b000, 7'b0100000, 32'h100);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_ready: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        sb_accept();
        tick();
        idle_in();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL reset_first_out: out_valid=%b want 1 (queued %0d)", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (out_operation !== 4'b0110 || out_tag !== 32'h100 || out_illegal !== e.ill) begin
                n_bad++;
                $display("FAIL reset_first_data: op=%b ill=%b tag=%h want op=0110 ill=0 tag=00000100",
                         out_operation, out_illegal, out_tag);
            end
        end
        tick();
    endtask

    task automatic test_decode_sweep();
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int f = 0; f < 8; f++) begin
                for (int s = 0; s < 2; s++) begin
                    if (i < 9) drive_in(opcs[i], f[2:0], s[0] ? 7'b0100000 : 7'b0000000, 32'(i * 16 + f * 2 + s));
                    else idle_in();
                    @(negedge clk);
                    n_cmp++;
                    if (out_valid !== (sb.size() != 0)) begin
                        n_bad++;
                        $display("FAIL sweep_valid: out_valid=%b want %b", out_valid, sb.size() != 0);
                    end
                    if (out_valid === 1'b1 && sb.size() != 0) begin
                        e = sb.pop_front();
                        n_cmp++;
                        if (out_operation !== e.op || out_illegal !== e.ill || out_tag !== e.tag) begin
                            n_bad++;
                            $display("FAIL sweep_data: op=%b ill=%b tag=%h want op=%b ill=%b tag=%h",
                                     out_operation, out_illegal, out_tag, e.op, e.ill, e.tag);
                        end
                    end
                    sb_accept();
                    tick();
                    if (i == 9) break;
                end
                if (i == 9) break;
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        drive_in(7'b0010011, 3'b000, 7'b0000000, 32'h300);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready0: in_ready=%b want 1", in_ready); end
        sb_accept();
        tick();
        drive_in(7'b0110011, 3'b100, 7'b0000000, 32'h301);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1: in_ready=%b want 1", in_ready); end
        sb_accept();
        tick();
        drive_in(7'b0110011, 3'b111, 7'b0000000, 32'h302);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: in_ready=%b want 0", in_ready); end
            n_cmp++;
            if (out_valid !== 1'b1 || out_operation !== 4'b0010 || out_tag !== 32'h300) begin
                n_bad++;
                $display("FAIL bp_head_hold: vld=%b op=%b tag=%h want vld=1 op=0010 tag=00000300",
                         out_valid, out_operation, out_tag);
            end
            sb_accept();
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) idle_in();
            @(negedge clk);
            if (k == 1) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_return: in_ready=%b want 1", in_ready); end
            end
            n_cmp++;
            if (out_valid !== (sb.size() != 0)) begin
                n_bad++;
                $display("FAIL bp_valid: out_valid=%b want %b", out_valid, sb.size() != 0);
            end
            if (out_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (out_operation !== e.op || out_illegal !== e.ill || out_tag !== e.tag) begin
                    n_bad++;
                    $display("FAIL bp_order: op=%b ill=%b tag=%h want op=%b ill=%b tag=%h",
                             out_operation, out_illegal, out_tag, e.op, e.ill, e.tag);
                end
            end
            sb_accept();
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive_in(opcs[$urandom_range(0, 7)], 3'($urandom_range(0, 7)),
                                7'($urandom_range(0, 1) << 5), 32'h200 + 32'(k));
            else idle_in();
            @(negedge clk);
            n_cmp++;
            if (out_valid !== (k >= 1 && k <= 8)) begin
                n_bad++;
                $display("FAIL stream_valid: cycle %0d out_valid=%b want %b", k, out_valid, (k >= 1 && k <= 8));
            end
            if (out_valid === 1'b1 && sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (out_operation !== e.op || out_illegal !== e.ill || out_tag !== e.tag) begin
                    n_bad++;
                    $display("FAIL stream_data: op=%b ill=%b tag=%h want op=%b ill=%b tag=%h",
                             out_operation, out_illegal, out_tag, e.op, e.ill, e.tag);
                end
            end
            sb_accept();
            tick();
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_in(7'b0000011, 3'b010, 7'b0000000, 32'h400);
        @(negedge clk); sb_accept(); tick();
        drive_in(7'b0100011, 3'b010, 7'b0000000, 32'h401);
        @(negedge clk); sb_accept(); tick();
        drive_in(7'b1100011, 3'b000, 7'b0000000, 32'h402);
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_full_state: rdy=%b vld=%b want rdy=0 vld=1", in_ready, out_valid);
        end
        sb.delete();
        tick();
        flush = 1'b0;
        idle_in();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_after_full: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        tick();
        // Partially full: ready is high, so only flush priority drops the BEQ
        drive_in(7'b1101111, 3'b000, 7'b0000000, 32'h410);
        @(negedge clk); sb_accept(); tick();
        drive_in(7'b1100011, 3'b000, 7'b0000000, 32'h411);
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_one_state: rdy=%b vld=%b want rdy=1 vld=1", in_ready, out_valid);
        end
        sb.delete();
        tick();
        flush = 1'b0;
        idle_in();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL flush_dropped: vld=%b rdy=%b tag=%h want vld=0 rdy=1", out_valid, in_ready, out_tag);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        out_ready = 1'b0;
        drive_in(7'b0110111, 3'b000, 7'b0000000, 32'h500);
        @(negedge clk); sb_accept(); tick();
        idle_in();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre: out_valid=%b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 32'h0 || out_operation !== 4'b0) begin
            n_bad++;
            $display("FAIL arst_immediate: vld=%b rdy=%b op=%b tag=%h want vld=0 rdy=1 op=0000 tag=0",
                     out_valid, in_ready, out_operation, out_tag);
        end
        sb.delete();
        @(negedge clk) reset = 1'b0;
        tick();
        out_ready = 1'b1;
        drive_in(7'b0110011, 3'b000, 7'b0000000, 32'h600);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: in_ready=%b want 1", in_ready); end
        @(negedge clk); sb_accept(); tick();
        idle_in();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL arst_recover_valid: out_valid=%b want 1", out_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (out_operation !== 4'b0010 || out_illegal !== e.ill || out_tag !== e.tag) begin
                n_bad++;
                $display("FAIL arst_recover_data: op=%b tag=%h want op=0010 tag=%h", out_operation, out_tag, e.tag);
            end
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_drain: out_valid=%b want 0", out_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
